// File: rtl/bloom_lut_ctrl_if.sv
// Bloom LUT controller bus: string gate, engine handshake, lookup port,
// host command port and status.
interface bloom_lut_ctrl_if #(
  parameter int HASHES_CNT = 6,
  parameter int HASH_W     = 12
);
  logic                         valid_i;
  logic                         ready_o;
  logic                         eng_valid_o;
  logic                         eng_ready_i;
  logic [HASHES_CNT*HASH_W-1:0] lut_address_i;
  logic [HASHES_CNT-1:0]        lut_readdata_o;
  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  logic                         cmd_op_i;
  logic [HASHES_CNT-1:0]        cmd_mask_i;
  logic [HASHES_CNT*HASH_W-1:0] cmd_addr_i;
  logic                         cmd_bit_i;
  logic                         busy_o;
  logic                         init_done_o;

  // Controller side
  modport slave (
    input  valid_i, eng_ready_i, lut_address_i,
    input  cmd_valid_i, cmd_op_i, cmd_mask_i, cmd_addr_i, cmd_bit_i,
    output ready_o, eng_valid_o, lut_readdata_o, cmd_ready_o, busy_o, init_done_o
  );

  // Source / engine / host side
  modport master (
    output valid_i, eng_ready_i, lut_address_i,
    output cmd_valid_i, cmd_op_i, cmd_mask_i, cmd_addr_i, cmd_bit_i,
    input  ready_o, eng_valid_o, lut_readdata_o, cmd_ready_o, busy_o, init_done_o
  );
endinterface

// File: rtl/bloom_lut_ctrl.sv
// Bloom filter LUT owner: gates new strings during maintenance, drains
// in-flight lookups, applies host bit writes / full clears, and clears all
// banks after reset before the gate first opens.
module bloom_lut_ctrl #(
  parameter int HASHES_CNT   = 6,
  parameter int HASH_W       = 12,
  parameter int DRAIN_CYCLES = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  bloom_lut_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** HASH_W;

  typedef enum logic [1:0] {SWEEP, PASS, DRAIN, EXEC} state_t;

  state_t            state;
  logic [HASH_W-1:0] sweep_cnt;
  logic [7:0]        drain_cnt;
  logic              sweep_clr;   // current sweep came from CLEAR_ALL
  logic              init_done;
  logic              gate_open;
  logic              cmd_acc;

  assign gate_open = (state == PASS);
  assign cmd_acc   = (state == EXEC) && bus.cmd_valid_i;

  // Gate is combinational so a closed gate blocks the transfer in the same cycle
  assign bus.eng_valid_o = gate_open & bus.valid_i;
  assign bus.ready_o     = gate_open & bus.eng_ready_i;
  assign bus.cmd_ready_o = (state == EXEC);
  assign bus.busy_o      = (state != PASS);
  assign bus.init_done_o = init_done;

  // Maintenance scheduler: sweep / pass / drain / execute
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
      drain_cnt <= '0;
      sweep_clr <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) begin
            sweep_clr <= 1'b0;
            if (sweep_clr) begin
              state <= EXEC;
            end else begin
              state     <= PASS;
              init_done <= 1'b1;
            end
          end
        end
        PASS: begin
          if (bus.cmd_valid_i) begin
            state     <= DRAIN;
            drain_cnt <= 8'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == 8'd0) state <= EXEC;
          else                   drain_cnt <= drain_cnt - 8'd1;
        end
        EXEC: begin
          if (!bus.cmd_valid_i) begin
            state <= PASS;
          end else if (bus.cmd_op_i) begin
            state     <= SWEEP;
            sweep_clr <= 1'b1;
            sweep_cnt <= '0;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  for (genvar h = 0; h < HASHES_CNT; h++) begin : g_bank
    logic [DEPTH-1:0]  mem;
    logic              we;
    logic [HASH_W-1:0] wa;
    logic              wd;
    logic              rd_q;

    // Per-bank write port: sweep clears, host WRITE sets masked banks
    always_comb begin
      we = 1'b0;
      wa = sweep_cnt;
      wd = 1'b0;
      if (state == SWEEP) begin
        we = 1'b1;
      end else if (cmd_acc && !bus.cmd_op_i && bus.cmd_mask_i[h]) begin
        we = 1'b1;
        wa = bus.cmd_addr_i[h*HASH_W +: HASH_W];
        wd = bus.cmd_bit_i;
      end
    end

    // LUT storage is left unreset; the reset sweep initialises it
    always_ff @(posedge clk_i) begin
      if (we) mem[wa] <= wd;
    end

    // Registered lookup; read-during-write returns old data
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rd_q <= 1'b0;
      else       rd_q <= mem[bus.lut_address_i[h*HASH_W +: HASH_W]];
    end

    assign bus.lut_readdata_o[h] = rd_q;
  end

endmodule

// File: tb/tb_bloom_lut_ctrl.sv
// Bench for bloom_lut_ctrl: lookups go through an expected-value queue
// checked by a separate monitor; control timing is checked inline.
module tb_bloom_lut_ctrl;
  localparam int HC = 2;
  localparam int HW = 4;
  localparam int DC = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bloom_lut_ctrl_if #(.HASHES_CNT(HC), .HASH_W(HW)) bus ();

  bloom_lut_ctrl #(.HASHES_CNT(HC), .HASH_W(HW), .DRAIN_CYCLES(DC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       lk_req;
  logic       lk_pend;
  logic [1:0] exp_q[$];
  logic       measure;
  int         closed_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup result appears one edge after the address is sampled
  always @(posedge clk) lk_pend <= lk_req;

  // Scoreboard monitor: pops an expectation whenever a lookup result is due
  always @(negedge clk) begin
    if (lk_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lookup_unexpected actual=%0h required=none", bus.lut_readdata_o);
      end else begin
        chk("lookup", 32'(bus.lut_readdata_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Gate-closed cycle counter for the back-to-back test
  always @(negedge clk) begin
    if (measure && bus.valid_i && !bus.ready_o) closed_cnt++;
  end

  task automatic lookup(input logic [3:0] a1, input logic [3:0] a0, input logic [1:0] exp);
    bus.lut_address_i = {a1, a0};
    lk_req = 1'b1;
    exp_q.push_back(exp);
    tick();
    lk_req = 1'b0;
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy_o && n < 100);
    chk(name, 32'(n), 32'd16);
    chk({name, "_init_done"}, 32'(bus.init_done_o), 32'd1);
  endtask

  // Present a command and hold it until one accepting edge has passed
  task automatic send_cmd(input logic op, input logic [1:0] mask, input logic [3:0] a1,
                          input logic [3:0] a0, input logic b);
    int n;
    bus.cmd_op_i   = op;
    bus.cmd_mask_i = mask;
    bus.cmd_addr_i = {a1, a0};
    bus.cmd_bit_i  = b;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready_o) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout actual=%0d required=<50", n);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    lk_req = 1'b0;
    measure = 1'b0;
    closed_cnt = 0;
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.eng_ready_i = 1'b1;
    bus.lut_address_i = '0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i = 1'b0;
    bus.cmd_mask_i = '0;
    bus.cmd_addr_i = '0;
    bus.cmd_bit_i = 1'b0;

    // Reset values
    #3;
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("rst_eng_valid", 32'(bus.eng_valid_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_readdata", 32'(bus.lut_readdata_o), 32'd0);
    chk("rst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd1);
    #19 rst = 1'b0;

    // Reset sweep
    count_sweep("reset_sweep");
    lookup(4'h0, 4'hF, 2'b00);
    lookup(4'h7, 4'h3, 2'b00);
    lookup(4'hA, 4'h5, 2'b00);

    // PASS streaming and combinational handshake
    for (int i = 0; i < 5; i++) begin
      chk("pass_stream", 32'({bus.eng_valid_o, bus.ready_o}), 32'b11);
      tick();
    end
    bus.eng_ready_i = 1'b0;
    #1 chk("pass_ready_follow", 32'(bus.ready_o), 32'd0);
    bus.valid_i = 1'b0;
    #1 chk("pass_valid_follow", 32'(bus.eng_valid_o), 32'd0);
    bus.valid_i = 1'b1;
    bus.eng_ready_i = 1'b1;
    tick();

    // Single WRITE with explicit drain timing
    bus.cmd_op_i = 1'b0;
    bus.cmd_mask_i = 2'b11;
    bus.cmd_addr_i = {4'h5, 4'hA};
    bus.cmd_bit_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    #1;
    chk("w_t_gate_open", 32'(bus.eng_valid_o), 32'd1);
    chk("w_t_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    tick();
    chk("w_t1_gate", 32'({bus.eng_valid_o, bus.ready_o}), 32'b00);
    chk("w_t1_busy", 32'(bus.busy_o), 32'd1);
    tick();
    tick();
    chk("w_t3_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    tick();
    chk("w_t4_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    #1 chk("w_exec_gate", 32'(bus.eng_valid_o), 32'd0);
    tick();
    chk("w_reopen", 32'({bus.eng_valid_o, bus.busy_o}), 32'b10);
    lookup(4'h5, 4'hA, 2'b11);
    lookup(4'h5, 4'hB, 2'b10);

    // Three back-to-back WRITEs share one drain
    closed_cnt = 0;
    measure = 1'b1;
    send_cmd(1'b0, 2'b01, 4'h9, 4'h1, 1'b1);
    send_cmd(1'b0, 2'b10, 4'h2, 4'h4, 1'b1);
    send_cmd(1'b0, 2'b11, 4'h5, 4'hA, 1'b0);
    bus.cmd_valid_i = 1'b0;
    tick();
    measure = 1'b0;
    chk("b2b_closed_cycles", 32'(closed_cnt), 32'd7);
    chk("b2b_busy", 32'(bus.busy_o), 32'd0);
    lookup(4'h9, 4'h1, 2'b01);
    lookup(4'h2, 4'h1, 2'b11);
    lookup(4'h5, 4'hA, 2'b00);
    lookup(4'h5, 4'h1, 2'b01);

    // WRITE then CLEAR_ALL
    send_cmd(1'b0, 2'b01, 4'h0, 4'h3, 1'b1);
    send_cmd(1'b1, 2'b00, 4'h0, 4'h0, 1'b0);
    bus.cmd_valid_i = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.cmd_ready_o && n < 100) begin
        n++;
        tick();
      end
      chk("clear_cmd_ready_low", 32'(n), 32'd16);
    end
    chk("clear_init_done", 32'(bus.init_done_o), 32'd1);
    tick();
    chk("clear_back_pass", 32'(bus.busy_o), 32'd0);
    lookup(4'h3, 4'h3, 2'b00);
    lookup(4'h2, 4'h1, 2'b00);

    // Reset asserted during EXEC
    send_cmd(1'b0, 2'b11, 4'h3, 4'h3, 1'b1);
    bus.cmd_valid_i = 1'b0;
    tick();
    lookup(4'h3, 4'h3, 2'b11);
    bus.cmd_op_i = 1'b0;
    bus.cmd_mask_i = 2'b01;
    bus.cmd_addr_i = {4'h6, 4'h6};
    bus.cmd_valid_i = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.cmd_ready_o && n < 50) begin
        tick();
        n++;
      end
      chk("exec_reached", 32'(bus.cmd_ready_o), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("arst_gate", 32'({bus.eng_valid_o, bus.ready_o}), 32'b00);
    chk("arst_readdata", 32'(bus.lut_readdata_o), 32'd0);
    chk("arst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    #1 rst = 1'b0;
    count_sweep("rerun_sweep");
    lookup(4'h3, 4'h3, 2'b00);
    lookup(4'h6, 4'h6, 2'b00);

    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
